// File: rtl/sprite_list_reader_if.sv
// rtl/sprite_list_reader_if.sv - sorted sprite entry stream towards the PPU fetcher
interface sprite_list_reader_if #(
  parameter int ADDR_W = 4
) ();
  logic              spr_valid_out;
  logic              spr_ready_in;
  logic [7:0]        spr_x_out;
  logic [7:0]        spr_tile_out;
  logic [7:0]        spr_attr_out;
  logic [ADDR_W-1:0] spr_idx_out;

  // Reader side drives the entry and valid, fetcher side answers with ready.
  modport master (
    output spr_valid_out, spr_x_out, spr_tile_out, spr_attr_out, spr_idx_out,
    input  spr_ready_in
  );

  modport slave (
    input  spr_valid_out, spr_x_out, spr_tile_out, spr_attr_out, spr_idx_out,
    output spr_ready_in
  );
endinterface

// File: rtl/sprite_list_reader.sv
// rtl/sprite_list_reader.sv - starts the sprite sorter per line and streams its sorted result buffer
module sprite_list_reader #(
  parameter int MAX_SPRITES = 10,
  parameter int ENTRY_W     = 32,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                line_start_in,
  output logic                sort_start_out,
  input  logic                sort_done_in,
  input  logic [ADDR_W-1:0]   sort_count_in,
  output logic [ADDR_W-1:0]   rd_addr_out,
  output logic                rd_en_out,
  input  logic [ENTRY_W-1:0]  rd_data_in,
  sprite_list_reader_if.master spr,
  output logic                list_done_out,
  output logic                timeout_err_out
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] MAX_L    = ADDR_W'(MAX_SPRITES);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SORT,
    S_FETCH,
    S_CAPTURE,
    S_PRESENT,
    S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic              start_q, start_d;
  logic              valid_q, valid_d;
  logic [7:0]        x_q, x_d;
  logic [7:0]        tile_q, tile_d;
  logic [7:0]        attr_q, attr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] count_clamped;
  logic              unused_y;

  // The y byte is already consumed by the sorter; the fetcher only needs x/tile/attr.
  assign unused_y = &rd_data_in[ENTRY_W-1:24];

  assign count_clamped = (sort_count_in > MAX_L) ? MAX_L : sort_count_in;

  // Next-state and datapath updates; a line start overrides everything and restarts the handshake.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    rd_idx_d = rd_idx_q;
    start_d  = 1'b0;
    valid_d  = valid_q;
    x_d      = x_q;
    tile_d   = tile_q;
    attr_d   = attr_q;
    idx_d    = idx_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: ;
      S_WAIT_SORT: begin
        if (sort_done_in) begin
          cnt_d    = count_clamped;
          rd_idx_d = '0;
          state_d  = (count_clamped == '0) ? S_FINISH : S_FETCH;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_FETCH: state_d = S_CAPTURE;
      S_CAPTURE: begin
        x_d     = rd_data_in[23:16];
        tile_d  = rd_data_in[15:8];
        attr_d  = rd_data_in[7:0];
        idx_d   = rd_idx_q;
        valid_d = 1'b1;
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (spr.spr_ready_in) begin
          valid_d  = 1'b0;
          rd_idx_d = rd_idx_q + ADDR_W'(1);
          state_d  = ((rd_idx_q + ADDR_W'(1)) == cnt_q) ? S_FINISH : S_FETCH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (line_start_in) begin
      start_d = 1'b1;
      valid_d = 1'b0;
      err_d   = 1'b0;
      tmo_d   = '0;
      state_d = S_WAIT_SORT;
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      cnt_q    <= '0;
      rd_idx_q <= '0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      x_q      <= '0;
      tile_q   <= '0;
      attr_q   <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      rd_idx_q <= rd_idx_d;
      start_q  <= start_d;
      valid_q  <= valid_d;
      x_q      <= x_d;
      tile_q   <= tile_d;
      attr_q   <= attr_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  assign sort_start_out    = start_q;
  assign rd_en_out         = (state_q == S_FETCH);
  assign rd_addr_out       = (state_q == S_FETCH) ? rd_idx_q : '0;
  assign list_done_out     = (state_q == S_FINISH);
  assign timeout_err_out   = err_q;
  assign spr.spr_valid_out = valid_q;
  assign spr.spr_x_out     = x_q;
  assign spr.spr_tile_out  = tile_q;
  assign spr.spr_attr_out  = attr_q;
  assign spr.spr_idx_out   = idx_q;

endmodule

// File: tb/tb_sprite_list_reader.sv
// tb/tb_sprite_list_reader.sv - directed checks of the sprite list reader
module tb_sprite_list_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_start_in = 1'b0;
  logic        sort_start_out;
  logic        sort_done_in = 1'b0;
  logic [3:0]  sort_count_in = '0;
  logic [3:0]  rd_addr_out;
  logic        rd_en_out;
  logic [31:0] rd_data_in = '0;
  logic        list_done_out;
  logic        timeout_err_out;

  logic [31:0] mem [0:15];
  int tests = 0;
  int failed = 0;

  int acc_cnt = 0;
  int ld_cnt = 0;
  int ss_cnt = 0;
  logic [7:0] log_x   [0:255];
  logic [3:0] log_idx [0:255];

  sprite_list_reader_if #(.ADDR_W(4)) spr_if ();

  sprite_list_reader dut (
    .clk             (clk),
    .rst             (rst),
    .line_start_in   (line_start_in),
    .sort_start_out  (sort_start_out),
    .sort_done_in    (sort_done_in),
    .sort_count_in   (sort_count_in),
    .rd_addr_out     (rd_addr_out),
    .rd_en_out       (rd_en_out),
    .rd_data_in      (rd_data_in),
    .spr             (spr_if),
    .list_done_out   (list_done_out),
    .timeout_err_out (timeout_err_out)
  );

  always #5 clk = ~clk;

  // Result buffer: synchronous RAM, one cycle read latency.
  always @(posedge clk) begin
    if (rd_en_out) rd_data_in <= mem[rd_addr_out];
  end

  // Event counters and accept log, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (spr_if.spr_valid_out && spr_if.spr_ready_in) begin
        log_x[acc_cnt % 256]   <= spr_if.spr_x_out;
        log_idx[acc_cnt % 256] <= spr_if.spr_idx_out;
        acc_cnt <= acc_cnt + 1;
      end
      if (list_done_out)  ld_cnt <= ld_cnt + 1;
      if (sort_start_out) ss_cnt <= ss_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_line();
    line_start_in = 1'b1;
    tick();
    line_start_in = 1'b0;
  endtask

  task automatic give_done(input logic [3:0] cnt);
    sort_done_in  = 1'b1;
    sort_count_in = cnt;
    tick();
    sort_done_in  = 1'b0;
    sort_count_in = '0;
  endtask

  initial begin
    int b_acc, b_ld, b_ss, n;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    spr_if.spr_ready_in = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_valid", spr_if.spr_valid_out, 0);
    chk("rst_start", sort_start_out, 0);
    chk("rst_rd_en", rd_en_out, 0);
    chk("rst_done", list_done_out, 0);
    chk("rst_err", timeout_err_out, 0);
    chk("rst_x", spr_if.spr_x_out, 0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("idle_start", sort_start_out, 0);
    chk("idle_rd_en", rd_en_out, 0);

    // Basic stream, done after 20 cycles, ready high
    mem[0] = 32'h1008_2A80;
    mem[1] = 32'h1010_2B00;
    mem[2] = 32'h1220_2C20;
    spr_if.spr_ready_in = 1'b1;
    b_acc = acc_cnt; b_ld = ld_cnt; b_ss = ss_cnt;
    pulse_line();
    chk("basic_start_hi", sort_start_out, 1);
    tick();
    chk("basic_start_lo", sort_start_out, 0);
    for (int i = 0; i < 18; i++) tick();
    give_done(4'd3);
    chk("basic_lat1", spr_if.spr_valid_out, 0);
    tick();
    chk("basic_lat2", spr_if.spr_valid_out, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("basic_valid", spr_if.spr_valid_out, 1);
      chk("basic_idx", spr_if.spr_idx_out, i);
      case (i)
        0: begin chk("basic_x0", spr_if.spr_x_out, 8'h08); chk("basic_t0", spr_if.spr_tile_out, 8'h2A); chk("basic_a0", spr_if.spr_attr_out, 8'h80); end
        1: begin chk("basic_x1", spr_if.spr_x_out, 8'h10); chk("basic_t1", spr_if.spr_tile_out, 8'h2B); chk("basic_a1", spr_if.spr_attr_out, 8'h00); end
        default: begin chk("basic_x2", spr_if.spr_x_out, 8'h20); chk("basic_t2", spr_if.spr_tile_out, 8'h2C); chk("basic_a2", spr_if.spr_attr_out, 8'h20); end
      endcase
      tick();
      chk("basic_drop", spr_if.spr_valid_out, 0);
      if (i < 2) begin
        chk("basic_no_done", list_done_out, 0);
        tick(); tick();
      end
    end
    chk("basic_list_done", list_done_out, 1);
    tick();
    chk("basic_list_done_lo", list_done_out, 0);
    chk("basic_accepts", acc_cnt - b_acc, 3);
    chk("basic_done_pulses", ld_cnt - b_ld, 1);
    chk("basic_start_pulses", ss_cnt - b_ss, 1);

    // Backpressure: first entry held for 7 cycles
    mem[0] = 32'hAA11_2233;
    mem[1] = 32'hBB44_5566;
    spr_if.spr_ready_in = 1'b0;
    b_acc = acc_cnt;
    pulse_line();
    give_done(4'd2);
    tick(); tick();
    chk("bp_valid", spr_if.spr_valid_out, 1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("bp_hold_valid", spr_if.spr_valid_out, 1);
      chk("bp_hold_x", spr_if.spr_x_out, 8'h11);
      chk("bp_hold_tile", spr_if.spr_tile_out, 8'h22);
      chk("bp_hold_attr", spr_if.spr_attr_out, 8'h33);
      chk("bp_hold_idx", spr_if.spr_idx_out, 0);
    end
    chk("bp_no_accept", acc_cnt - b_acc, 0);
    spr_if.spr_ready_in = 1'b1;
    tick();
    chk("bp_drop", spr_if.spr_valid_out, 0);
    tick(); tick();
    chk("bp_second_valid", spr_if.spr_valid_out, 1);
    chk("bp_second_x", spr_if.spr_x_out, 8'h44);
    chk("bp_second_idx", spr_if.spr_idx_out, 1);
    tick();
    chk("bp_list_done", list_done_out, 1);
    tick();
    chk("bp_accepts", acc_cnt - b_acc, 2);

    // Empty list
    b_acc = acc_cnt; b_ld = ld_cnt;
    pulse_line();
    give_done(4'd0);
    chk("empty_list_done", list_done_out, 1);
    chk("empty_valid", spr_if.spr_valid_out, 0);
    tick();
    chk("empty_done_lo", list_done_out, 0);
    chk("empty_accepts", acc_cnt - b_acc, 0);
    chk("empty_done_pulses", ld_cnt - b_ld, 1);

    // Clamp: count 15 yields 10 entries
    for (int i = 0; i < 16; i++) mem[i] = {8'h00, 8'(i * 3 + 1), 8'(8'h40 + i), 8'(i)};
    b_acc = acc_cnt;
    pulse_line();
    give_done(4'd15);
    n = 0;
    while (!list_done_out && n < 100) begin tick(); n++; end
    chk("clamp_done_seen", list_done_out, 1);
    tick();
    chk("clamp_accepts", acc_cnt - b_acc, 10);
    for (int k = 0; k < 10; k++) begin
      chk("clamp_idx", log_idx[(b_acc + k) % 256], k);
      chk("clamp_x", log_x[(b_acc + k) % 256], k * 3 + 1);
    end

    // Timeout: done never arrives
    b_acc = acc_cnt;
    pulse_line();
    for (int i = 0; i < 1022; i++) tick();
    chk("tmo_not_yet_err", timeout_err_out, 0);
    chk("tmo_not_yet_done", list_done_out, 0);
    tick();
    chk("tmo_err", timeout_err_out, 1);
    chk("tmo_list_done", list_done_out, 1);
    chk("tmo_valid", spr_if.spr_valid_out, 0);
    tick(); tick(); tick();
    chk("tmo_sticky", timeout_err_out, 1);
    chk("tmo_done_lo", list_done_out, 0);
    chk("tmo_accepts", acc_cnt - b_acc, 0);
    pulse_line();
    chk("tmo_err_cleared", timeout_err_out, 0);
    chk("tmo_restart", sort_start_out, 1);
    give_done(4'd0);
    tick();

    // Abort while idx 1 is held with ready low
    mem[0] = 32'h1008_2A80;
    mem[1] = 32'h1010_2B00;
    mem[2] = 32'h1220_2C20;
    spr_if.spr_ready_in = 1'b1;
    pulse_line();
    give_done(4'd3);
    tick(); tick();
    chk("abort_first_idx", spr_if.spr_idx_out, 0);
    tick();
    spr_if.spr_ready_in = 1'b0;
    tick(); tick();
    chk("abort_held_valid", spr_if.spr_valid_out, 1);
    chk("abort_held_idx", spr_if.spr_idx_out, 1);
    tick();
    b_ld = ld_cnt;
    pulse_line();
    chk("abort_valid_drop", spr_if.spr_valid_out, 0);
    chk("abort_restart", sort_start_out, 1);
    chk("abort_no_done", list_done_out, 0);
    give_done(4'd2);
    spr_if.spr_ready_in = 1'b1;
    tick(); tick();
    chk("abort_new_valid", spr_if.spr_valid_out, 1);
    chk("abort_new_idx", spr_if.spr_idx_out, 0);
    chk("abort_new_x", spr_if.spr_x_out, 8'h08);
    tick(); tick(); tick();
    chk("abort_new_idx1", spr_if.spr_idx_out, 1);
    tick();
    chk("abort_final_done", list_done_out, 1);
    tick();
    chk("abort_done_pulses", ld_cnt - b_ld, 1);

    // Asynchronous reset during PRESENT
    mem[0] = 32'h1234_5678;
    spr_if.spr_ready_in = 1'b0;
    pulse_line();
    give_done(4'd1);
    tick(); tick();
    chk("areset_pre_valid", spr_if.spr_valid_out, 1);
    #2 rst = 1'b1;
    #1;
    chk("areset_valid", spr_if.spr_valid_out, 0);
    chk("areset_x", spr_if.spr_x_out, 0);
    chk("areset_tile", spr_if.spr_tile_out, 0);
    chk("areset_attr", spr_if.spr_attr_out, 0);
    chk("areset_idx", spr_if.spr_idx_out, 0);
    chk("areset_rd_en", rd_en_out, 0);
    chk("areset_done", list_done_out, 0);
    tick();
    rst = 1'b0;
    spr_if.spr_ready_in = 1'b1;
    give_done(4'd2);
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_valid", spr_if.spr_valid_out, 0);
      chk("post_rst_rd_en", rd_en_out, 0);
      chk("post_rst_start", sort_start_out, 0);
      tick();
    end
    chk("post_rst_done", list_done_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/sprite_list_reader.md
Name: sprite_list_reader

Overview:
- Consumer/controller end of the sprite sort handshake. On each scanline trigger it pulses start to the sprite sorter, waits for done, then reads the sorted entries out of the sorter's result buffer.
- Buffer is a synchronous RAM with 1-cycle read latency.
- Streams entries in ascending address order to the PPU pixel fetcher over a valid/ready interface.
- Sits between pipeline_sort and the PPU fetch stage.

Parameters:
- MAX_SPRITES, 10, maximum entries per line; count input is clamped to this.
- ENTRY_W, 32, result entry width: [31:24] y, [23:16] x, [15:8] tile, [7:0] attr.
- ADDR_W, 4, result buffer address width (2^ADDR_W >= MAX_SPRITES).
- TIMEOUT, 1023, maximum cycles to wait for sorter done before aborting the line.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: asynchronous assertion, active-high, clears all state.
- line_start_in  in  1  1-cycle pulse marking the start of a scanline's sprite phase.
- sort_start_out  out  1  1-cycle start pulse to the sorter.
- sort_done_in  in  1  sorter done (level or pulse; the first high cycle is used).
- sort_count_in  in  ADDR_W  number of valid sorted entries; sampled on the cycle sort_done_in is first seen high.
- rd_addr_out  out  ADDR_W  result buffer read address.
- rd_en_out  out  1  result buffer read enable.
- rd_data_in  in  ENTRY_W  read data, valid the cycle after rd_en_out.
- spr_valid_out  out  1  output entry valid.
- spr_ready_in  in  1  fetcher accepts the entry.
- spr_x_out  out  8  entry x.
- spr_tile_out  out  8  entry tile.
- spr_attr_out  out  8  entry attr.
- spr_idx_out  out  ADDR_W  position of the entry in the sorted list.
- list_done_out  out  1  1-cycle pulse after the last entry is accepted, or immediately when the count is 0.
- timeout_err_out  out  1  sticky flag set on sorter timeout; cleared by the next line_start_in.

Behaviour:
- Reset values: all outputs 0. State is IDLE; counters are 0.
- States:
  - IDLE: on line_start_in, drive sort_start_out=1 for that next cycle, go to WAIT_SORT, clear the timeout counter.
  - WAIT_SORT: count cycles.
    - On sort_done_in: latch cnt = min(sort_count_in, MAX_SPRITES), set rd_idx=0. If cnt==0, go to FINISH; otherwise go to FETCH.
    - If the timeout counter reaches TIMEOUT with no done: set timeout_err_out, go to FINISH. No entries are emitted for that line.
  - FETCH: rd_en_out=1 and rd_addr_out=rd_idx for exactly one cycle, then go to CAPTURE.
  - CAPTURE: register rd_data_in into the output fields, set spr_idx_out=rd_idx and spr_valid_out=1, go to PRESENT.
  - PRESENT: hold valid and all fields stable until spr_ready_in is high.
    - On the accept cycle, valid drops next cycle and rd_idx increments.
    - If rd_idx+1==cnt, go to FINISH; otherwise go to FETCH.
  - FINISH: list_done_out=1 for one cycle, then go to IDLE.
- Timing:
  - Best-case throughput: one entry per 3 cycles.
  - Latency from sort_done_in to the first spr_valid_out: 3 cycles (WAIT_SORT -> FETCH -> CAPTURE -> valid visible).
- Handshake rules:
  - spr_valid_out never drops without an accept, except on abort or reset.
  - Fields never change while valid is high and ready is low.
  - spr_ready_in while valid is low is ignored.
- Abort: line_start_in in any non-IDLE state (including FINISH) aborts the current list.
  - Next cycle: valid=0, no list_done_out, timeout_err_out cleared, sort_start_out=1, state WAIT_SORT.
  - Any in-flight read data is discarded.
- sort_done_in seen outside WAIT_SORT is ignored.
- sort_count_in > MAX_SPRITES (e.g. 15) is clamped to MAX_SPRITES.
- Reset mid-operation: immediate return to reset values. Any pending start or done is forgotten.

Test Plan:
- Basic stream: line_start, then done after 20 cycles with count=3, buffer {0x10_08_2A_80, 0x10_10_2B_00, 0x12_20_2C_20}, ready held high -> sort_start pulses once; three entries come out in order with x=0x08,0x10,0x20, tile=0x2A,0x2B,0x2C, idx=0,1,2; list_done pulses once, 1 cycle after the third accept.
- Backpressure: count=2, ready low for 7 cycles on the first entry -> valid and fields stay constant for all 7 cycles; the second entry appears only after the accept; total of exactly 2 accepts.
- Empty and clamp cases:
  - count=0 -> no valid; list_done the cycle after done is sampled.
  - count=15 -> exactly 10 entries emitted, idx 0..9.
- Timeout: line_start with done never asserted -> after 1023 wait cycles, timeout_err_out=1 and list_done pulses with no valid. The next line_start clears timeout_err_out.
- Abort: second line_start while entry idx=1 is presented with ready low -> valid drops next cycle, no list_done, sort_start re-pulses, and the new list restarts at idx=0.
- Async reset: assert rst between clock edges during PRESENT -> all outputs 0 immediately. After release, the block stays idle until line_start.
